// File: rtl/cpu_ctrl_pkg.sv
// Shared run-controller definitions: state encodings and the rules that decide
// when the core is held in reset and when its state elements are enabled.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_STEP  = 3'd4
    } run_state_e;

    localparam logic [31:0] CYCLE_MAX = 32'hFFFF_FFFF;

    // The core sits in reset until it is first released into RUN or STEP.
    function automatic logic cpu_reset_rule(input run_state_e st);
        cpu_reset_rule = (st == ST_LOAD) || (st == ST_IDLE);
    endfunction

    // A halt or an unskipped breakpoint gates the enable in the very cycle it
    // appears, so the instruction at the breakpoint never executes.
    function automatic logic cpu_en_rule(
        input run_state_e st,
        input logic       halt,
        input logic       bp_hit,
        input logic       bp_skip
    );
        case (st)
            ST_RUN:  cpu_en_rule = !(halt || (bp_hit && !bp_skip));
            ST_STEP: cpu_en_rule = 1'b1;
            default: cpu_en_rule = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_imem_loader.sv
// Program loader: valid/ready write port into instruction memory with a word
// counter that doubles as the write address and the loaded program length.
module imem_loader
    import cpu_ctrl_pkg::*;
#(
    parameter int IMEM_AW = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               active,
    input  logic               clear,
    input  logic               load_valid,
    input  logic [31:0]        load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic [IMEM_AW:0]   prog_len,
    output logic               done
);

    localparam logic [IMEM_AW-1:0] LAST_ADDR = '1;
    localparam logic [IMEM_AW:0]   ONE       = 1;

    logic             armed;
    logic [IMEM_AW:0] count;

    // armed holds load_ready low for the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (!reset) begin
            armed <= 1'b0;
            count <= '0;
        end else begin
            armed <= 1'b1;
            if (clear) begin
                count <= '0;
            end else if (imem_we) begin
                count <= count + ONE;
            end
        end
    end

    assign load_ready = active && armed;
    assign imem_we    = load_valid && load_ready;
    assign imem_waddr = count[IMEM_AW-1:0];
    assign imem_wdata = load_data;
    assign prog_len   = count;
    // The last memory word ends the load even without load_last; no wrap.
    assign done       = imem_we && (load_last || (imem_waddr == LAST_ADDR));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle core: loads a program while the core is
// held in reset, then runs, halts, single-steps and breakpoints it via cpu_en.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int IMEM_AW = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    input  logic [31:0]        load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    input  logic               cmd_run,
    input  logic               cmd_step,
    input  logic               cmd_halt,
    input  logic               cmd_reload,
    input  logic               bp_en,
    input  logic [31:0]        bp_addr,
    input  logic [31:0]        pc_in,
    output logic               cpu_reset,
    output logic               cpu_en,
    output logic [2:0]         state_out,
    output logic [IMEM_AW:0]   prog_len,
    output logic [31:0]        cycle_count
);

    run_state_e state;
    logic       bp_skip;
    logic       bp_hit;
    logic       load_done;
    logic       reload_ok;

    assign bp_hit    = bp_en && (pc_in == bp_addr);
    assign cpu_reset = cpu_reset_rule(state);
    assign cpu_en    = cpu_en_rule(state, cmd_halt, bp_hit, bp_skip);
    assign state_out = state;
    assign reload_ok = cmd_reload && ((state == ST_IDLE) || (state == ST_PAUSE));

    imem_loader #(
        .IMEM_AW(IMEM_AW)
    ) u_loader (
        .clk       (clk),
        .reset     (reset),
        .active    (state == ST_LOAD),
        .clear     (reload_ok),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_ready(load_ready),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .prog_len  (prog_len),
        .done      (load_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_LOAD;
            bp_skip     <= 1'b0;
            cycle_count <= '0;
        end else begin
            bp_skip <= 1'b0;
            if (cpu_en && !cpu_reset && (cycle_count != CYCLE_MAX)) begin
                cycle_count <= cycle_count + 32'd1;
            end
            case (state)
                ST_LOAD: begin
                    if (load_done) state <= ST_IDLE;
                end
                ST_IDLE, ST_PAUSE: begin
                    if (cmd_reload) begin
                        state       <= ST_LOAD;
                        cycle_count <= '0;
                    end else if (cmd_step) begin
                        state <= ST_STEP;
                    end else if (cmd_run) begin
                        state <= ST_RUN;
                        // Resuming from a pause must execute the instruction at bp_addr.
                        bp_skip <= (state == ST_PAUSE);
                    end
                end
                ST_RUN: begin
                    if (!cpu_en) state <= ST_PAUSE;
                end
                ST_STEP: state <= ST_PAUSE;
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with randomized program words, lengths, gaps
// and breakpoint positions; the core is modelled as a PC that advances by 4.
module tb_cpu_run_ctrl;

    localparam int AW = 6;
    localparam logic [31:0] S_LOAD = 0, S_IDLE = 1, S_RUN = 2, S_PAUSE = 3, S_STEP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_valid = 1'b0;
    logic [31:0]   load_data = '0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0, cmd_reload = 1'b0;
    logic          bp_en = 1'b0;
    logic [31:0]   bp_addr = '0;
    logic [31:0]   pc_in = '0;
    logic          cpu_reset;
    logic          cpu_en;
    logic [2:0]    state_out;
    logic [AW:0]   prog_len;
    logic [31:0]   cycle_count;

    int tests = 0;
    int failed = 0;
    int en_seen = 0;
    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] got_q[$];

    logic [31:0] d;
    int n, len, k, gap, en_base, run_len;

    cpu_run_ctrl #(.IMEM_AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_halt   (cmd_halt),
        .cmd_reload (cmd_reload),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc_in      (pc_in),
        .cpu_reset  (cpu_reset),
        .cpu_en     (cpu_en),
        .state_out  (state_out),
        .prog_len   (prog_len),
        .cycle_count(cycle_count)
    );

    // clock / watchdog
    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: record writes, let the edge happen, advance the core PC, drop pulses.
    task automatic tick();
        logic en_s, rst_s;
        #1;
        en_s  = cpu_en;
        rst_s = cpu_reset;
        if (imem_we === 1'b1) got_q.push_back({imem_waddr, imem_wdata});
        if (en_s === 1'b1 && rst_s === 1'b0) en_seen++;
        @(posedge clk);
        #1;
        if (rst_s === 1'b1) pc_in = 32'd0;
        else if (en_s === 1'b1) pc_in = pc_in + 32'd4;
        @(negedge clk);
        cmd_run = 1'b0;
        cmd_step = 1'b0;
        cmd_halt = 1'b0;
        cmd_reload = 1'b0;
        #1;
    endtask

    task automatic check_sb(input string tag);
        logic [AW+31:0] g, e;
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_addr"}, 32'(g[AW+31:32]), 32'(e[AW+31:32]));
            chk({tag, "_data"}, g[31:0], e[31:0]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // reset
        @(negedge clk);
        #1;
        repeat (2) tick();
        load_valid = 1'b1;
        #1;
        chk("rst_state", 32'(state_out), S_LOAD);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_load_ready", 32'(load_ready), 0);
        chk("rst_cpu_reset", 32'(cpu_reset), 1);
        chk("rst_cpu_en", 32'(cpu_en), 0);
        chk("rst_prog_len", 32'(prog_len), 0);
        chk("rst_cycle_count", cycle_count, 0);
        load_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(load_ready), 0);
        tick();
        chk("rdy_after_edge", 32'(load_ready), 1);

        // four-word load ending on load_last
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            load_valid = 1'b1;
            load_data = d;
            load_last = (i == 3);
            exp_q.push_back({AW'(i), d});
            #1;
            chk("load4_we", 32'(imem_we), 1);
            chk("load4_cpu_reset", 32'(cpu_reset), 1);
            tick();
        end
        load_valid = 1'b0;
        load_last = 1'b0;
        #1;
        chk("load4_state", 32'(state_out), S_IDLE);
        chk("load4_prog_len", 32'(prog_len), 4);
        chk("load4_ready_off", 32'(load_ready), 0);
        chk("load4_cpu_reset_idle", 32'(cpu_reset), 1);
        check_sb("load4");

        // full-depth load with load_valid toggling, no load_last
        cmd_reload = 1'b1;
        tick();
        chk("reload_state", 32'(state_out), S_LOAD);
        chk("reload_prog_len", 32'(prog_len), 0);
        chk("reload_ready", 32'(load_ready), 1);
        n = 0;
        for (int c = 0; c < 300 && state_out == S_LOAD[2:0]; c++) begin
            load_valid = (c % 2 == 0);
            if (load_valid) begin
                d = $urandom;
                load_data = d;
                exp_q.push_back({AW'(n), d});
                n++;
            end
            tick();
        end
        load_valid = 1'b1;
        load_data = $urandom;
        #1;
        chk("full_state", 32'(state_out), S_IDLE);
        chk("full_writes", 32'(got_q.size()), 64);
        chk("full_prog_len", 32'(prog_len), 64);
        chk("full_ready_off", 32'(load_ready), 0);
        chk("full_no_we_idle", 32'(imem_we), 0);
        load_valid = 1'b0;
        check_sb("full");

        // run, reload ignored in RUN, then halt together with run
        run_len = $urandom_range(6, 20);
        cmd_run = 1'b1;
        tick();
        chk("run_state", 32'(state_out), S_RUN);
        chk("run_cpu_reset", 32'(cpu_reset), 0);
        chk("run_first_pc", pc_in, 0);
        for (int i = 0; i < run_len; i++) begin
            if (i == 3) cmd_reload = 1'b1;
            #1;
            chk("run_en", 32'(cpu_en), 1);
            tick();
        end
        chk("run_reload_ignored", 32'(state_out), S_RUN);
        cmd_halt = 1'b1;
        cmd_run = 1'b1;
        #1;
        chk("halt_en_same_cycle", 32'(cpu_en), 0);
        tick();
        chk("halt_state", 32'(state_out), S_PAUSE);
        chk("halt_cycle_count", cycle_count, 32'(run_len));
        chk("halt_pc", pc_in, 32'(4 * run_len));

        // three spaced single steps; a breakpoint does not stop a step
        en_base = en_seen;
        for (int s = 0; s < 3; s++) begin
            gap = $urandom_range(1, 4);
            repeat (gap) tick();
            if (s == 1) begin
                bp_en = 1'b1;
                bp_addr = pc_in;
            end
            cmd_step = 1'b1;
            #1;
            chk("step_pause_en", 32'(cpu_en), 0);
            tick();
            chk("step_state", 32'(state_out), S_STEP);
            chk("step_en", 32'(cpu_en), 1);
            tick();
            chk("step_back_pause", 32'(state_out), S_PAUSE);
            chk("step_after_en", 32'(cpu_en), 0);
            bp_en = 1'b0;
        end
        chk("step_en_cycles", 32'(en_seen - en_base), 3);
        chk("step_cycle_count", cycle_count, 32'(run_len + 3));
        chk("step_pc", pc_in, 32'(4 * (run_len + 3)));

        // reload from PAUSE with a random-length program and gappy valid
        cmd_reload = 1'b1;
        tick();
        chk("reload2_state", 32'(state_out), S_LOAD);
        chk("reload2_cycle_count", cycle_count, 0);
        chk("reload2_prog_len", 32'(prog_len), 0);
        len = $urandom_range(8, 20);
        n = 0;
        for (int c = 0; c < 200 && n < len; c++) begin
            load_valid = ($urandom_range(0, 2) != 0);
            load_last = (n == len - 1);
            if (load_valid) begin
                d = $urandom;
                load_data = d;
                exp_q.push_back({AW'(n), d});
            end
            tick();
            if (load_valid) n++;
        end
        load_valid = 1'b0;
        load_last = 1'b0;
        #1;
        chk("load_rand_state", 32'(state_out), S_IDLE);
        chk("load_rand_prog_len", 32'(prog_len), 32'(len));
        check_sb("load_rand");

        // breakpoint at 0x8 from a fresh start
        bp_en = 1'b1;
        bp_addr = 32'h8;
        cmd_run = 1'b1;
        tick();
        for (int c = 0; c < 50 && state_out != S_PAUSE[2:0]; c++) tick();
        chk("bp_state", 32'(state_out), S_PAUSE);
        chk("bp_pc", pc_in, 32'h8);
        chk("bp_cycle_count", cycle_count, 2);
        cmd_run = 1'b1;
        tick();
        #1;
        chk("bp_resume_en", 32'(cpu_en), 1);
        tick();
        chk("bp_resume_pc", pc_in, 32'hC);
        cmd_halt = 1'b1;
        tick();
        chk("bp_resume_halt_state", 32'(state_out), S_PAUSE);
        chk("bp_resume_cycle_count", cycle_count, 3);

        // breakpoint at a random later word
        k = $urandom_range(5, 20);
        bp_addr = 32'(4 * k);
        cmd_run = 1'b1;
        tick();
        for (int c = 0; c < 100 && state_out != S_PAUSE[2:0]; c++) tick();
        chk("bp2_state", 32'(state_out), S_PAUSE);
        chk("bp2_pc", pc_in, 32'(4 * k));
        chk("bp2_cycle_count", cycle_count, 32'(k));

        // reset while running aborts to LOAD with counters cleared
        bp_en = 1'b0;
        cmd_run = 1'b1;
        tick();
        repeat (3) tick();
        chk("pre_reset_state", 32'(state_out), S_RUN);
        reset = 1'b0;
        tick();
        chk("runrst_state", 32'(state_out), S_LOAD);
        chk("runrst_prog_len", 32'(prog_len), 0);
        chk("runrst_cycle_count", cycle_count, 0);
        chk("runrst_cpu_reset", 32'(cpu_reset), 1);
        chk("runrst_cpu_en", 32'(cpu_en), 0);
        chk("runrst_ready", 32'(load_ready), 0);
        reset = 1'b1;
        #1;
        chk("runrst_ready_hold", 32'(load_ready), 0);
        tick();
        chk("runrst_ready_rise", 32'(load_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
